// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute-stage ALU fed by the 4-bit ALU-control code. It returns a registered
// result with zero and signed-overflow flags over a valid/ready handshake.
// Logic, arithmetic and compare ops complete in one cycle. By default, shifts
// move one bit per cycle.
//
// Build option:
//   ALU_BARREL_SHIFT_EN - when defined, SLL/SRL/SRA use a combinational barrel
//                         shifter with latency 1. The SHIFT state and the
//                         shift counter are removed. Results are identical in
//                         both builds; only the latency differs.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready = unit idle)
//   sel                 operation code
//   src_a, src_b        operands; src_b is the operand that gets shifted
//   shamt               shift amount
//   out_valid,out_ready result handshake
//   result, zero        registered result, result == 0
//   overflow            signed overflow, ADD/SUB only
//   busy                unit is not idle
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// SHIFT  | iterative shift in progress, result_q is the working register
// DONE   | result valid, held until out_ready

module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         sel,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               busy
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0011;
    localparam logic [3:0] SEL_SLT = 4'b0100;
    localparam logic [3:0] SEL_SLL = 4'b0101;
    localparam logic [3:0] SEL_SRL = 4'b0110;
    localparam logic [3:0] SEL_SRA = 4'b0111;
    localparam logic [3:0] SEL_XOR = 4'b1001;
    localparam logic [3:0] SEL_NOR = 4'b1010;

`ifdef ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

`ifndef ALU_BARREL_SHIFT_EN
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    // Low two bits of sel identify the shift kind: 01 SLL, 10 SRL, 11 SRA.
    logic [1:0]         shop_q, shop_d;
    logic [WIDTH-1:0]   shifted;
    logic               is_shift;
`endif

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    // Single-cycle datapath, evaluated on the live inputs in the accept cycle.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (sel)
            SEL_AND: alu_res = src_a & src_b;
            SEL_OR:  alu_res = src_a | src_b;
            SEL_ADD: begin
                alu_res = sum;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            SEL_SUB: begin
                alu_res = diff;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            // Signed compare on the operands directly, so it is immune to
            // overflow in a-b.
            SEL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_BARREL_SHIFT_EN
            SEL_SLL: alu_res = src_b << shamt;
            SEL_SRL: alu_res = src_b >> shamt;
            SEL_SRA: alu_res = $unsigned($signed(src_b) >>> shamt);
`else
            // Only reached with shamt == 0; non-zero amounts go to SHIFT.
            SEL_SLL, SEL_SRL, SEL_SRA: alu_res = src_b;
`endif
            SEL_XOR: alu_res = src_a ^ src_b;
            SEL_NOR: alu_res = ~(src_a | src_b);
            default: alu_res = '0;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    assign is_shift = (sel == SEL_SLL) || (sel == SEL_SRL) || (sel == SEL_SRA);

    always_comb begin
        case (shop_q)
            2'b01:   shifted = {result_q[WIDTH-2:0], 1'b0};
            2'b10:   shifted = {1'b0, result_q[WIDTH-1:1]};
            default: shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        endcase
    end
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`ifndef ALU_BARREL_SHIFT_EN
        cnt_d    = cnt_q;
        shop_d   = shop_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        state_d  = ST_SHIFT;
                        result_d = src_b;
                        zero_d   = 1'b0;
                        ovf_d    = 1'b0;
                        cnt_d    = shamt;
                        shop_d   = sel[1:0];
                    end else
`endif
                    begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                    end
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                result_d = shifted;
                cnt_d    = cnt_q - SHAMT_W'(1);
                // zero is only published with the final shifted value.
                zero_d   = 1'b0;
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                    zero_d  = (shifted == '0);
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_q    <= '0;
            shop_q   <= 2'b00;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_q    <= cnt_d;
            shop_q   <= shop_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  sel = 4'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .src_a(src_a), .src_b(src_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {overflow, result}, from plain arithmetic.
    function automatic logic [32:0] model_calc(input logic [3:0] s, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        longint      sa, sb, wide;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (s)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin wide = sa + sb; r = wide[31:0]; ov = (wide != longint'($signed(r))); end
            4'd3:  begin wide = sa - sb; r = wide[31:0]; ov = (wide != longint'($signed(r))); end
            4'd4:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  r = b << sh;
            4'd6:  r = b >> sh;
            4'd7:  begin wide = sb >>> sh; r = wide[31:0]; end
            4'd9:  r = a ^ b;
            4'd10: r = ~(a | b);
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    function automatic int model_lat(input logic [3:0] s, input logic [4:0] sh);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if ((s == 4'd5 || s == 4'd6 || s == 4'd7) && sh != 5'd0) return int'(sh) + 1;
        return 1;
`endif
    endfunction

    // Transaction-level model: idle / waiting-for-latency / holding-result.
    logic        m_busy, m_valid, m_zero, m_ovf;
    logic [31:0] m_res;
    logic [32:0] m_pend;
    int          m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_res   <= '0;
            m_zero  <= 1'b1;
            m_ovf   <= 1'b0;
            m_wait  <= 0;
            m_pend  <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                if (model_lat(sel, shamt) == 1) begin
                    m_valid <= 1'b1;
                    m_res   <= model_calc(sel, src_a, src_b, shamt);
                    m_zero  <= (model_calc(sel, src_a, src_b, shamt) & 33'h0_FFFF_FFFF) == 33'd0;
                    m_ovf   <= model_calc(sel, src_a, src_b, shamt) > 33'h0_FFFF_FFFF;
                end else begin
                    m_wait <= model_lat(sel, shamt) - 1;
                    m_pend <= model_calc(sel, src_a, src_b, shamt);
                    m_zero <= 1'b0;
                    m_ovf  <= 1'b0;
                end
            end
        end else if (!m_valid) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend[31:0];
                m_zero  <= (m_pend[31:0] == 32'd0);
                m_ovf   <= m_pend[32];
            end
        end else if (out_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("m_zero", {31'd0, zero}, {31'd0, m_zero});
            chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (!m_busy || m_valid) chk("m_result", result, m_res);
        end
    end

    task automatic do_op(input string nm, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                         input logic ez, input logic eo, input int elat, input int hold);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b1; sel = s; src_a = a; src_b = b; shamt = sh; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; sel = 4'd2; src_a = ~a; src_b = ~b; shamt = ~sh;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_result"}, result, er);
        chk({nm, "_zero"}, {31'd0, zero}, {31'd0, ez});
        chk({nm, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            sel = 4'd2; src_a = $urandom; src_b = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (hold > 0) chk({nm, "_held"}, result, er);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int sra_lat;
`ifdef ALU_BARREL_SHIFT_EN
        sra_lat = 1;
`else
        sra_lat = 32;
`endif
        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        do_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1, 1, 0);
        do_op("sub_zero", 4'b0011, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1'b0, 1, 0);
        do_op("sub_ovf", 4'b0011, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 1, 0);
        do_op("slt_neg", 4'b0100, 32'h80000000, 32'h00000001, 5'd0, 32'd1, 1'b0, 1'b0, 1, 0);
        do_op("slt_ovf", 4'b0100, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 1'b0, 1, 0);
        do_op("sra31", 4'b0111, 32'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, sra_lat, 0);
        do_op("sll0", 4'b0101, 32'h0, 32'h00000001, 5'd0, 32'd1, 1'b0, 1'b0, 1, 0);
        do_op("xor_bp", 4'b1001, 32'hF0F0F0F0, 32'hFFFF0000, 5'd0, 32'h0F0FF0F0, 1'b0, 1'b0, 1, 10);
        do_op("undef", 4'b1100, 32'h12345678, 32'h9ABCDEF0, 5'd7, 32'd0, 1'b1, 1'b0, 1, 0);
        do_op("nop", 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'd0, 1'b1, 1'b0, 1, 0);
        do_op("nor", 4'b1010, 32'h0000FFFF, 32'h00FF0000, 5'd0, 32'hFF000000, 1'b0, 1'b0, 1, 0);
        do_op("and", 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 32'h0F000F00, 1'b0, 1'b0, 1, 0);
        do_op("or", 4'b0001, 32'hA0000005, 32'h0A000050, 5'd0, 32'hAA000055, 1'b0, 1'b0, 1, 0);
`ifdef ALU_BARREL_SHIFT_EN
        do_op("srl4", 4'b0110, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1'b0, 1'b0, 1, 0);
        do_op("sll31", 4'b0101, 32'h0, 32'h00000003, 5'd31, 32'h80000000, 1'b0, 1'b0, 1, 2);
        do_op("sra3pos", 4'b0111, 32'h0, 32'h40000000, 5'd3, 32'h08000000, 1'b0, 1'b0, 1, 0);
        do_op("sll_out", 4'b0101, 32'h0, 32'h00000001, 5'd1, 32'h00000002, 1'b0, 1'b0, 1, 0);
`else
        do_op("srl4", 4'b0110, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1'b0, 1'b0, 5, 0);
        do_op("sll31", 4'b0101, 32'h0, 32'h00000003, 5'd31, 32'h80000000, 1'b0, 1'b0, 32, 2);
        do_op("sra3pos", 4'b0111, 32'h0, 32'h40000000, 5'd3, 32'h08000000, 1'b0, 1'b0, 4, 0);
        do_op("sll_out", 4'b0101, 32'h0, 32'h00000001, 5'd1, 32'h00000002, 1'b0, 1'b0, 2, 0);
`endif
        do_op("srl_zero", 4'b0110, 32'h0, 32'h00000001, 5'd1, 32'h0, 1'b1, 1'b0, model_lat(4'd6, 5'd1), 0);

        // Reset in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1; sel = 4'b0111; src_b = 32'h80000000; shamt = 5'd20; src_a = '0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit `sel` code produced by the ALU control decoder, together with two operands and a shift amount.
- Returns a registered result, plus zero and overflow flags, over a valid/ready handshake.
- Shifts are iterative, one bit per cycle, to save area. All other operations complete in one cycle.
- Sits between the ID/EX operand registers and the EX/MEM result register; the pipeline stalls on `in_ready` low.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request this cycle
- sel  input  4  operation code: AND=0000 OR=0001 ADD=0010 SUB=0011 SLT=0100 SLL=0101 SRL=0110 SRA=0111 XOR=1001 NOR=1010 NOP=1111
- src_a  input  WIDTH  operand A (rs)
- src_b  input  WIDTH  operand B (rt or immediate); this is the operand that gets shifted
- shamt  input  SHAMT_W  shift amount
- out_valid  output  1  result, zero and overflow are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- overflow  output  1  signed overflow, ADD/SUB only
- busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; result=0, zero=1, overflow=0, out_valid=0, busy=0, in_ready=1.
  - Takes effect immediately, including mid-shift or while holding a result; any in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- Inputs are accepted on a rising edge with in_valid && in_ready. `in_ready` = (state==IDLE). `sel`, `src_a`, `src_b` and `shamt` are captured at acceptance; later changes to them are ignored.
- IDLE, on accept:
  - Non-shift op: compute and register the result and flags; go to DONE. out_valid rises the cycle after acceptance (latency 1).
  - SLL/SRL/SRA with shamt==0: result=src_b; go to DONE (latency 1).
  - SLL/SRL/SRA with shamt=k>0: load src_b into the working register, load the counter with k, go to SHIFT.
- SHIFT:
  - Each cycle, shift the working register 1 bit: SLL fills 0 on the right; SRL fills 0 on the left; SRA replicates the MSB.
  - Decrement the counter. When the counter reaches 0, go to DONE.
  - Total latency is k+1 cycles from acceptance to out_valid, so k=31 gives 32 cycles.
- DONE:
  - out_valid=1. result, zero and overflow are held stable while out_ready is low.
  - On out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle bypass.
- Arithmetic, all at WIDTH bits with wrap-around:
  - ADD: a+b. overflow = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB: a-b. overflow = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - SLT: signed compare; result = {0..0, a<b}. The comparison is correct even when a-b overflows.
  - NOR: ~(a|b).
  - overflow=0 for every op except ADD/SUB.
- Undefined sel codes (1000, 1011–1110) and NOP produce result=0, zero=1, overflow=0, with latency 1, and still complete the handshake.
- `zero` is derived from the final result only; it is never asserted during SHIFT.
- in_valid asserted while busy is ignored. No request is queued.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: SLL/SRL/SRA use a combinational barrel shifter and complete with latency 1 like every other op. The SHIFT state and shift counter are not generated.
- Undefined: iterative shift as described above, with latency shamt+1.
- Results are bit-identical in both builds; only the latency differs.

Test Plan:
- Reset mid-shift: start SRA shamt=20, assert rst_n low at cycle 5 → out_valid=0, result=0 and zero=1 immediately; next accept after release behaves normally.
- ADD a=0x7FFFFFFF b=0x00000001 → result=0x80000000, overflow=1, zero=0, out_valid 1 cycle after accept. SUB a=5 b=5 → result=0, zero=1, overflow=0.
- SLT a=0x80000000 b=0x00000001 → result=1. SLT a=0x7FFFFFFF b=0xFFFFFFFF → result=0 (overflow case).
- SRA src_b=0x80000000 shamt=31 → result=0xFFFFFFFF, out_valid exactly 32 cycles after accept, in_ready=0 throughout. SLL src_b=1 shamt=0 → result=1, latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after an XOR a=0xF0F0F0F0 b=0xFFFF0000 → result held at 0x0F0FF0F0, in_valid pulses are ignored, and in_ready returns 1 the cycle after out_ready is asserted.
- Undefined sel=1100 with any operands → result=0, zero=1, overflow=0, handshake completes in 1 cycle. In the ALU_BARREL_SHIFT_EN build, repeat the SRA case and check result 0xFFFFFFFF with latency 1.
